// File: rtl/prt_sequencer.sv
// Pulse-repetition sequencer driving the AD9914 update/pre-trigger/trigger strobes.
// Optional macro PRT_SEQ_BURST_EN adds burst_len and ends a run after that many frames.
module prt_sequencer #(
  parameter int UPD_W = 4,
  parameter int PRE_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] prt_period,
  input  logic [15:0] pre_offset,
  input  logic [15:0] trig_offset,
  input  logic [15:0] trig_width,
  input  logic [7:0]  ct_interval,
`ifdef PRT_SEQ_BURST_EN
  input  logic [15:0] burst_len,
`endif
  output logic        ad9914_update_1,
  output logic        ad9914_update_2,
  output logic        ad9914_pre_trig_1,
  output logic        ad9914_trig_1,
  output logic        busy,
  output logic        cfg_err,
  output logic [15:0] prt_index,
  output logic        run_done
);

  // state | meaning
  // IDLE  | waiting for start; pending stop cleared
  // CHECK | one cycle: latch and validate config
  // RUN   | frames repeating, pos counts 0..prt_period-1
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN} state_t;

  state_t      state;
  logic [31:0] pos, prt_l;
  logic [15:0] pre_l, trig_off_l, trig_w_l;
  logic [7:0]  ct_l, ct_cnt;
  logic        ct_hit, stop_pend;
`ifdef PRT_SEQ_BURST_EN
  logic [15:0] burst_rem;
`endif

  logic        cfg_ok, frame_end, run_end, new_frame, nxt_hit;
  logic        d_upd1, d_pre, d_trig;
  logic [31:0] nxt_pos;
  logic [7:0]  ct_src, cnt_cur, nxt_cnt;
  logic [15:0] cfg_pre, cfg_toff, cfg_tw;
  logic [32:0] q, pre33, toff33;

  always_comb begin
    cfg_ok = (33'(UPD_W) <= {17'd0, pre_offset})
          && ({17'd0, pre_offset} + 33'(PRE_W) <= {17'd0, trig_offset})
          && (trig_width != 16'd0)
          && ({17'd0, trig_offset} + {17'd0, trig_width} <= {1'b0, prt_period});
`ifdef PRT_SEQ_BURST_EN
    cfg_ok = cfg_ok && (burst_len != 16'd0);
`endif
    frame_end = (pos == prt_l - 32'd1);
    run_end   = frame_end && (stop_pend || stop);
`ifdef PRT_SEQ_BURST_EN
    run_end   = run_end || (frame_end && burst_rem == 16'd1);
`endif
    nxt_pos   = (state == S_RUN && !frame_end) ? pos + 32'd1 : 32'd0;
    new_frame = (state == S_CHECK) || (state == S_RUN && frame_end);

    // In CHECK the latched copies are not loaded yet, so decode from the inputs.
    cfg_pre  = (state == S_CHECK) ? pre_offset  : pre_l;
    cfg_toff = (state == S_CHECK) ? trig_offset : trig_off_l;
    cfg_tw   = (state == S_CHECK) ? trig_width  : trig_w_l;
    ct_src   = (state == S_CHECK) ? ct_interval : ct_l;
    cnt_cur  = (state == S_CHECK) ? 8'd0        : ct_cnt;

    nxt_hit = ct_hit;
    nxt_cnt = ct_cnt;
    if (new_frame) begin
      nxt_hit = (ct_src != 8'd0) && (cnt_cur == 8'd0);
      nxt_cnt = nxt_hit ? ct_src - 8'd1 : cnt_cur - 8'd1;
    end

    q      = {1'b0, nxt_pos};
    pre33  = {17'd0, cfg_pre};
    toff33 = {17'd0, cfg_toff};
    d_upd1 = q < 33'(UPD_W);
    d_pre  = (q >= pre33) && (q < pre33 + 33'(PRE_W));
    d_trig = (q >= toff33) && (q < toff33 + {17'd0, cfg_tw});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= S_IDLE;
      pos               <= '0;
      prt_l             <= '0;
      pre_l             <= '0;
      trig_off_l        <= '0;
      trig_w_l          <= '0;
      ct_l              <= '0;
      ct_cnt            <= '0;
      ct_hit            <= 1'b0;
      stop_pend         <= 1'b0;
`ifdef PRT_SEQ_BURST_EN
      burst_rem         <= '0;
`endif
      ad9914_update_1   <= 1'b0;
      ad9914_update_2   <= 1'b0;
      ad9914_pre_trig_1 <= 1'b0;
      ad9914_trig_1     <= 1'b0;
      busy              <= 1'b0;
      cfg_err           <= 1'b0;
      prt_index         <= '0;
      run_done          <= 1'b0;
    end else begin
      run_done <= 1'b0;
      case (state)
        S_IDLE: begin
          stop_pend         <= 1'b0;
          ad9914_update_1   <= 1'b0;
          ad9914_update_2   <= 1'b0;
          ad9914_pre_trig_1 <= 1'b0;
          ad9914_trig_1     <= 1'b0;
          if (start && !stop) begin
            state <= S_CHECK;
            busy  <= 1'b1;
          end
        end
        S_CHECK: begin
          prt_l      <= prt_period;
          pre_l      <= pre_offset;
          trig_off_l <= trig_offset;
          trig_w_l   <= trig_width;
          ct_l       <= ct_interval;
          if (cfg_ok) begin
            state             <= S_RUN;
            cfg_err           <= 1'b0;
            prt_index         <= '0;
            pos               <= '0;
            ct_cnt            <= nxt_cnt;
            ct_hit            <= nxt_hit;
`ifdef PRT_SEQ_BURST_EN
            burst_rem         <= burst_len;
`endif
            ad9914_update_1   <= d_upd1;
            ad9914_update_2   <= d_upd1 && nxt_hit;
            ad9914_pre_trig_1 <= d_pre;
            ad9914_trig_1     <= d_trig;
          end else begin
            state   <= S_IDLE;
            cfg_err <= 1'b1;
            busy    <= 1'b0;
          end
        end
        S_RUN: begin
          if (stop) stop_pend <= 1'b1;
          if (frame_end) begin
            prt_index <= prt_index + 16'd1;
`ifdef PRT_SEQ_BURST_EN
            burst_rem <= burst_rem - 16'd1;
`endif
          end
          if (run_end) begin
            state             <= S_IDLE;
            busy              <= 1'b0;
            run_done          <= 1'b1;
            ad9914_update_1   <= 1'b0;
            ad9914_update_2   <= 1'b0;
            ad9914_pre_trig_1 <= 1'b0;
            ad9914_trig_1     <= 1'b0;
          end else begin
            pos               <= nxt_pos;
            ct_cnt            <= nxt_cnt;
            ct_hit            <= nxt_hit;
            ad9914_update_1   <= d_upd1;
            ad9914_update_2   <= d_upd1 && nxt_hit;
            ad9914_pre_trig_1 <= d_pre;
            ad9914_trig_1     <= d_trig;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prt_sequencer.sv
// Bench for prt_sequencer: frame-arithmetic reference model plus directed literal checks.
// Define PRT_SEQ_BURST_EN to also exercise the burst-length feature.
`timescale 1ns/1ps
module tb_prt_sequencer;
  localparam int UPD_W = 4;
  localparam int PRE_W = 4;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0;
  logic [31:0] prt_period = 32'd100;
  logic [15:0] pre_offset = 16'd10, trig_offset = 16'd20, trig_width = 16'd30;
  logic [7:0]  ct_interval = 8'd0;
`ifdef PRT_SEQ_BURST_EN
  logic [15:0] burst_len = 16'hFFFF;
`endif
  logic        upd1, upd2, pre, trig, busy, cfg_err, run_done;
  logic [15:0] prt_index;

  prt_sequencer #(.UPD_W(UPD_W), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .prt_period(prt_period), .pre_offset(pre_offset), .trig_offset(trig_offset),
    .trig_width(trig_width), .ct_interval(ct_interval),
`ifdef PRT_SEQ_BURST_EN
    .burst_len(burst_len),
`endif
    .ad9914_update_1(upd1), .ad9914_update_2(upd2), .ad9914_pre_trig_1(pre),
    .ad9914_trig_1(trig), .busy(busy), .cfg_err(cfg_err), .prt_index(prt_index),
    .run_done(run_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference model: outputs derived from elapsed cycles since the first frame.
  int     m_mode;  // 0 idle, 1 check, 2 run
  longint rel, end_frame, frame, off;
  longint c_prt, c_pre, c_toff, c_tw, c_ct;
  logic   e_upd1, e_upd2, e_pre, e_trig, e_busy, e_err, e_done;
  logic [15:0] e_idx;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0;
      {e_upd1, e_upd2, e_pre, e_trig, e_busy, e_err, e_done} = '0;
      e_idx = '0;
    end else begin
      e_done = 1'b0;
      case (m_mode)
        0: if (start && !stop) begin m_mode = 1; e_busy = 1'b1; end
        1: begin
          if (UPD_W <= longint'(pre_offset) && longint'(pre_offset) + PRE_W <= longint'(trig_offset)
              && trig_width != 0 && longint'(trig_offset) + longint'(trig_width) <= longint'(prt_period)
`ifdef PRT_SEQ_BURST_EN
              && burst_len != 0
`endif
             ) begin
            c_prt = prt_period; c_pre = pre_offset; c_toff = trig_offset;
            c_tw = trig_width; c_ct = ct_interval;
            rel = 0;
`ifdef PRT_SEQ_BURST_EN
            end_frame = longint'(burst_len) - 1;
`else
            end_frame = 64'h7FFF_FFFF_FFFF;
`endif
            e_err = 1'b0; m_mode = 2;
          end else begin
            e_err = 1'b1; e_busy = 1'b0; m_mode = 0;
          end
        end
        default: begin
          frame = rel / c_prt;
          if (stop && end_frame > frame) end_frame = frame;
          if (rel % c_prt == c_prt - 1 && frame == end_frame) begin
            m_mode = 0; e_busy = 1'b0; e_done = 1'b1;
            e_idx = 16'(frame + 1);
          end else rel++;
        end
      endcase
      if (m_mode == 2) begin
        frame  = rel / c_prt;
        off    = rel % c_prt;
        e_upd1 = off < UPD_W;
        e_upd2 = e_upd1 && c_ct != 0 && (frame % c_ct) == 0;
        e_pre  = off >= c_pre && off < c_pre + PRE_W;
        e_trig = off >= c_toff && off < c_toff + c_tw;
        e_idx  = 16'(frame);
      end else begin
        {e_upd1, e_upd2, e_pre, e_trig} = '0;
      end
    end
  end

  always @(negedge clk) begin
    chk("update_1", 32'(upd1), 32'(e_upd1));
    chk("update_2", 32'(upd2), 32'(e_upd2));
    chk("pre_trig", 32'(pre), 32'(e_pre));
    chk("trig", 32'(trig), 32'(e_trig));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("cfg_err", 32'(cfg_err), 32'(e_err));
    chk("run_done", 32'(run_done), 32'(e_done));
    chk("prt_index", 32'(prt_index), 32'(e_idx));
  end

  int n_upd1, n_upd2, n_pre, n_trig;
  always @(negedge clk) begin
    if (upd1) n_upd1++;
    if (upd2) n_upd2++;
    if (pre)  n_pre++;
    if (trig) n_trig++;
  end

  task automatic at_cycle(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic set_cfg(input int p, input int pr, input int to, input int tw, input int ct);
    prt_period = 32'(p); pre_offset = 16'(pr); trig_offset = 16'(to);
    trig_width = 16'(tw); ct_interval = 8'(ct);
  endtask

  task automatic do_start(output int t);
    @(posedge clk); #1;
    n_upd1 = 0; n_upd2 = 0; n_pre = 0; n_trig = 0;
    start = 1'b1; t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_stop(input int n);
    at_cycle(n); stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask

  int t, tgt;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_idx", 32'(prt_index), 0);
    chk("rst_upd1", 32'(upd1), 0);
    rst = 1'b1;

    // Basic frame, stop during frame 1
    set_cfg(100, 10, 20, 30, 0);
    do_start(t);
    at_cycle(t + 1);   chk("busy_check", 32'(busy), 1);
    at_cycle(t + 2);   chk("upd1_first", 32'(upd1), 1);
    at_cycle(t + 5);   chk("upd1_last", 32'(upd1), 1);
    at_cycle(t + 6);   chk("upd1_off", 32'(upd1), 0);
    at_cycle(t + 12);  chk("pre_first", 32'(pre), 1);
    at_cycle(t + 15);  chk("pre_last", 32'(pre), 1);
    at_cycle(t + 16);  chk("pre_off", 32'(pre), 0);
    at_cycle(t + 21);  chk("trig_before", 32'(trig), 0);
    at_cycle(t + 22);  chk("trig_first", 32'(trig), 1);
    at_cycle(t + 51);  chk("trig_last", 32'(trig), 1);
    at_cycle(t + 52);  chk("trig_off", 32'(trig), 0);
    at_cycle(t + 102); chk("upd1_frame1", 32'(upd1), 1);
    chk("idx_frame1", 32'(prt_index), 1);
    pulse_stop(t + 110);
    at_cycle(t + 201); chk("busy_last", 32'(busy), 1);
    at_cycle(t + 202); chk("done_basic", 32'(run_done), 1);
    chk("busy_end", 32'(busy), 0);
    at_cycle(t + 203); chk("done_pulse", 32'(run_done), 0);
    chk("n_upd2_ct0", 32'(n_upd2), 0);
    chk("n_upd1_basic", 32'(n_upd1), 8);
    chk("n_trig_basic", 32'(n_trig), 60);

    // CT cadence, 7 frames, start during run ignored
    set_cfg(20, 4, 8, 5, 3);
    do_start(t);
    at_cycle(t + 2);  chk("upd2_f0", 32'(upd2), 1);
    at_cycle(t + 22); chk("upd2_f1", 32'(upd2), 0);
    at_cycle(t + 50); start = 1'b1; @(negedge clk); start = 1'b0;
    at_cycle(t + 62); chk("upd2_f3", 32'(upd2), 1);
    pulse_stop(t + 125);
    at_cycle(t + 142); chk("done_ct", 32'(run_done), 1);
    at_cycle(t + 145);
    chk("n_upd2_ct3", 32'(n_upd2), 12);
    chk("n_upd1_ct3", 32'(n_upd1), 28);

    // Bad config, then valid start and stop mid-trigger of frame 2
    set_cfg(100, 20, 22, 5, 0);
    do_start(t);
    at_cycle(t + 1);  chk("bad_busy1", 32'(busy), 1);
    at_cycle(t + 2);  chk("bad_cfg_err", 32'(cfg_err), 1);
    chk("bad_busy2", 32'(busy), 0);
    at_cycle(t + 20);
    chk("bad_n_upd1", 32'(n_upd1), 0);
    chk("bad_n_trig", 32'(n_trig + n_pre), 0);
    set_cfg(30, 4, 10, 5, 1);
    do_start(t);
    at_cycle(t + 2);  chk("err_cleared", 32'(cfg_err), 0);
    chk("upd2_every", 32'(upd2), 1);
    pulse_stop(t + 74);
    at_cycle(t + 76); chk("trig_not_cut", 32'(trig), 1);
    at_cycle(t + 91); chk("busy_f2_end", 32'(busy), 1);
    at_cycle(t + 92); chk("done_stop", 32'(run_done), 1);
    at_cycle(t + 100);
    chk("n_trig_stop", 32'(n_trig), 15);
    chk("n_upd1_stop", 32'(n_upd1), 12);

    // Reset mid-trigger
    do_start(t);
    at_cycle(t + 43); chk("pre_rst_trig", 32'(trig), 1);
    chk("pre_rst_idx", 32'(prt_index), 1);
    #2 rst = 1'b0;
    #1 chk("rst_trig", 32'(trig), 0);
    chk("rst_idx_mid", 32'(prt_index), 0);
    chk("rst_busy_mid", 32'(busy), 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    n_upd1 = 0; n_trig = 0;
    tgt = cyc + 80;
    at_cycle(tgt);
    chk("post_rst_upd1", 32'(n_upd1), 0);
    chk("post_rst_trig", 32'(n_trig), 0);
    chk("post_rst_busy", 32'(busy), 0);

`ifdef PRT_SEQ_BURST_EN
    burst_len = 16'd4;
    set_cfg(50, 5, 10, 10, 2);
    do_start(t);
    at_cycle(t + 60); start = 1'b1; @(negedge clk); start = 1'b0;
    at_cycle(t + 201); chk("burst_busy", 32'(busy), 1);
    at_cycle(t + 202); chk("burst_done", 32'(run_done), 1);
    chk("burst_busy_end", 32'(busy), 0);
    at_cycle(t + 210);
    chk("burst_n_upd1", 32'(n_upd1), 16);
    chk("burst_n_upd2", 32'(n_upd2), 8);
    burst_len = 16'hFFFF;
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
